axi4_lite_master_arbiter: RTL

Round-robin arbiter that shares one `AXI4_Lite_Master` internal command port (`addr`/`write`/`wdata`/`transfer`, returning `ready`/`rdata`) among `NUM_REQ` requesters. It latches the winning request and drives a single-cycle `transfer` pulse. It then waits for the master's `ready` and returns completion plus read data to the owning requester. The block sits between on-chip requesters and the AXI4-Lite master. Exactly one transaction is outstanding at a time.

---
 rtl/axi4_lite_master_arbiter_pkg.sv | 14 +
 rtl/axi4_lite_master_arbiter_if.sv | 22 ++
 rtl/axi4_lite_master_arbiter_rr_picker.sv | 33 +++
 rtl/axi4_lite_master_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/axi4_lite_master_arbiter_pkg.sv
// Shared types and default sizing for the AXI4-Lite master command-port arbiter.
package axi4_lite_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_e;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_ADDR_W  = 4;
    localparam int ARB_DATA_W  = 32;

endpackage

// File: rtl/axi4_lite_master_arbiter_if.sv
// Command port between the arbiter and the AXI4-Lite master engine.
interface axi4_lite_master_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_addr;
    logic              m_write;
    logic [DATA_W-1:0] m_wdata;
    logic              m_transfer;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_addr, m_write, m_wdata, m_transfer,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_addr, m_write, m_wdata, m_transfer,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/axi4_lite_master_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_picker
    import axi4_lite_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    int idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        // k = NUM_REQ lands back on 'last', so the previous owner is lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ
// requesters; one transaction outstanding, transfer pulse, registered completion.
module axi4_lite_master_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    parameter  int ADDR_W  = ARB_ADDR_W,
    parameter  int DATA_W  = ARB_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_rdata,
    axi4_lite_master_arbiter_if.master m_bus,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     grant_id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_REQ-1:0]  done_q;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_valid),
        .last   (last_grant_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (m_bus.m_ready) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            done_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            if (state_q == ARB_IDLE && pick_any) begin
                grant_id_q <= pick_id;
                addr_q     <= req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                write_q    <= req_write[pick_id];
                wdata_q    <= req_wdata[int'(pick_id)*DATA_W +: DATA_W];
            end
            // read data is captured for writes too; requesters ignore it then
            if (state_q == ARB_WAIT && m_bus.m_ready) begin
                rdata_q             <= m_bus.m_rdata;
                last_grant_q        <= grant_id_q;
                done_q[grant_id_q]  <= 1'b1;
            end
        end
    end

    always_comb begin
        req_accept = '0;
        if (state_q == ARB_ISSUE) req_accept[grant_id_q] = 1'b1;
    end

    assign m_bus.m_transfer = (state_q == ARB_ISSUE);
    assign m_bus.m_addr     = addr_q;
    assign m_bus.m_write    = write_q;
    assign m_bus.m_wdata    = wdata_q;
    assign req_done         = done_q;
    assign req_rdata        = rdata_q;
    assign busy             = (state_q != ARB_IDLE);
    assign grant_id         = grant_id_q;

endmodule
